button_event_ctrl: RTL

- Front-end controller for the alarm clock's push-buttons (set, hour, minute, alarm-off, …).
- Per button: 2-FF synchronisation, then debounce, then press / long-press / auto-repeat event generation.
- Pending events from all buttons are arbitrated onto one valid/ready event channel.
- The consumer is the time/alarm setting FSM.

---
 rtl/button_event_ctrl_pkg.sv | 25 ++
 rtl/button_event_ctrl_if.sv | 18 +
 rtl/button_event_ctrl_debounce.sv | 121 ++++++++++++
 rtl/button_event_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared types for the push-button front end.
//   EVT_*       : event-kind encodings carried on the event channel
//   btn_state_e : per-button debounce / hold state
//   pend_t      : one pending-event slot (valid + kind)
package btn_pkg;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_PRESS  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_REPEAT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEATING,
    DB_REL
  } btn_state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] kind;
  } pend_t;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Button event channel (valid/ready).
//   evt_valid : event available (producer)
//   evt_ready : consumer accepts on evt_valid & evt_ready
//   evt_id    : index of the button that produced the event
//   evt_kind  : PRESS / LONG / REPEAT
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  localparam int ID_W = $clog2(N_BTN);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_kind;

  modport master (output evt_valid, evt_id, evt_kind, input  evt_ready);
  modport slave  (input  evt_valid, evt_id, evt_kind, output evt_ready);
endinterface

// File: rtl/button_event_ctrl_debounce.sv
// One button: 2-FF synchroniser, debounce FSM and hold timer.
//   clk, rst_n : clock, async active-low reset
//   raw        : asynchronous button pin (active high)
//   level      : debounced level
//   post       : single-cycle event strobe, valid in the cycle before the
//                FSM transition that generates it
//   post_kind  : kind of the posted event
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 100,
  parameter int REPEAT_CYC   = 25,
  parameter int CNT_W        = $clog2(LONG_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  output logic       level,
  output logic       post,
  output logic [1:0] post_kind
);

  localparam logic [CNT_W-1:0] T_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_T  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] LNG_T = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] REP_T = CNT_W'(REPEAT_CYC - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  btn_state_e       state, state_nx;
  logic [CNT_W-1:0] tmr, tmr_nx, tmr_sav, tmr_sav_nx, tmr_inc;
  logic             ret_rep, ret_rep_nx, level_nx;

  assign sync    = sync_ff[1];
  // Saturate rather than wrap.
  assign tmr_inc = (tmr == '1) ? tmr : tmr + T_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      state   <= IDLE;
      tmr     <= '0;
      tmr_sav <= '0;
      ret_rep <= 1'b0;
      level   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      state   <= state_nx;
      tmr     <= tmr_nx;
      tmr_sav <= tmr_sav_nx;
      ret_rep <= ret_rep_nx;
      level   <= level_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tmr_nx     = tmr;
    tmr_sav_nx = tmr_sav;
    ret_rep_nx = ret_rep;
    level_nx   = level;
    post       = 1'b0;
    post_kind  = EVT_NONE;
    case (state)
      IDLE: if (sync) begin
        state_nx = DB_PRESS;
        tmr_nx   = T_ONE;
      end
      DB_PRESS: begin
        if (!sync) state_nx = IDLE;
        else if (tmr == DB_T) begin
          state_nx  = HELD;
          level_nx  = 1'b1;
          post      = 1'b1;
          post_kind = EVT_PRESS;
          tmr_nx    = '0;
        end else tmr_nx = tmr_inc;
      end
      HELD: begin
        if (!sync) begin
          // Hold timer is parked while the release is being qualified so a
          // short bounce resumes the hold count where it left off.
          state_nx   = DB_REL;
          tmr_sav_nx = tmr;
          ret_rep_nx = 1'b0;
          tmr_nx     = T_ONE;
        end else if (tmr == LNG_T) begin
          state_nx  = REPEATING;
          post      = 1'b1;
          post_kind = EVT_LONG;
          tmr_nx    = '0;
        end else tmr_nx = tmr_inc;
      end
      REPEATING: begin
        if (!sync) begin
          state_nx   = DB_REL;
          tmr_sav_nx = tmr;
          ret_rep_nx = 1'b1;
          tmr_nx     = T_ONE;
        end else if (tmr == REP_T) begin
          post      = 1'b1;
          post_kind = EVT_REPEAT;
          tmr_nx    = '0;
        end else tmr_nx = tmr_inc;
      end
      DB_REL: begin
        if (sync) begin
          state_nx = ret_rep ? REPEATING : HELD;
          tmr_nx   = tmr_sav;
        end else if (tmr == DB_T) begin
          state_nx = IDLE;
          level_nx = 1'b0;
          tmr_nx   = '0;
        end else tmr_nx = tmr_inc;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Push-button front end: N_BTN debounce FSMs, one pending slot per button,
// fixed-priority (lowest index) arbitration onto a registered event channel.
//   clk, rst_n : clock, async active-low reset
//   btn_raw    : raw button pins
//   btn_level  : debounced levels
//   evt        : event channel (master side)
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 100,
  parameter int REPEAT_CYC   = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_BTN-1:0]        btn_raw,
  output logic [N_BTN-1:0]        btn_level,
  button_event_ctrl_if.master     evt
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam int ID_W  = $clog2(N_BTN);

  logic [N_BTN-1:0]      post;
  logic [N_BTN-1:0][1:0] post_kind;
  pend_t [N_BTN-1:0]     pend;
  logic                  win_vld, load;
  logic [ID_W-1:0]       win_id;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CNT_W        (CNT_W)
    ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (btn_raw[i]),
      .level     (btn_level[i]),
      .post      (post[i]),
      .post_kind (post_kind[i])
    );
  end

  // Lowest pending index wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i].vld) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  assign load = !evt.evt_valid || evt.evt_ready;

  // Set beats clear: a post landing on the slot being consumed survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (post[i])                                  pend[i] <= {1'b1, post_kind[i]};
        else if (load && win_vld && win_id == ID_W'(i)) pend[i].vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt.evt_valid <= 1'b0;
      evt.evt_id    <= '0;
      evt.evt_kind  <= EVT_NONE;
    end else if (load) begin
      evt.evt_valid <= win_vld;
      if (win_vld) begin
        evt.evt_id   <= win_id;
        evt.evt_kind <= pend[win_id].kind;
      end
    end
  end

endmodule
